// File: rtl/axis_chan_arb_pkg.sv
// Shared types, constants and the round-robin pick used by the channel arbiter.
package axis_chan_arb_pkg;

  typedef enum logic {ST_IDLE, ST_XFER} state_e;

  localparam int unsigned PKT_CNT_W = 32;
  localparam int unsigned RR_MAX_CH = 16;
  localparam int unsigned RR_IDX_W  = 4;

  // First set request bit strictly after ptr, wrapping modulo n.
  function automatic logic [RR_IDX_W-1:0] rr_pick(input logic [RR_MAX_CH-1:0] req,
                                                  input logic [RR_IDX_W-1:0]  ptr,
                                                  input int unsigned          n);
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    int unsigned         cand;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_CH; k++) begin
      if (k <= n) begin
        cand = (32'(ptr) + k) % n;
        if (!found && req[cand[RR_IDX_W-1:0]]) begin
          idx   = cand[RR_IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_rr_arb.sv
// Round-robin arbiter: combinational pick from request+pointer, registered grant on load.
module axis_rr_arb
  import axis_chan_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          load_i,
  output logic [IW-1:0] pick_idx_o,
  output logic [IW-1:0] grant_idx_o,
  output logic [N-1:0]  grant_oh_o
);

  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic [N-1:0]  grant_oh_q, grant_oh_d;
  logic [RR_MAX_CH-1:0] req_ext;

  assign req_ext    = RR_MAX_CH'(req_i);
  assign pick_idx_o = IW'(rr_pick(req_ext, RR_IDX_W'(ptr_i), N));

  always_comb begin
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    if (load_i && (|req_i)) begin
      grant_idx_d = pick_idx_o;
      grant_oh_d  = N'(1) << pick_idx_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
    end else begin
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
    end
  end

  assign grant_idx_o = grant_idx_q;
  assign grant_oh_o  = grant_oh_q;

endmodule

// File: rtl/axis_chan_arb.sv
// N-channel AXI4-Stream packet arbiter: packet-granular round-robin merge with
// channel-ID sideband, per-channel packet counters and over-length detection.
module axis_chan_arb
  import axis_chan_arb_pkg::*;
#(
  parameter  int unsigned CH_NUM    = 4,
  parameter  int unsigned DWIDTH    = 512,
  parameter  int unsigned KWIDTH    = 64,
  parameter  int unsigned UWIDTH    = 64,
  parameter  int unsigned MAX_BEATS = 256,
  localparam int unsigned CH_W      = $clog2(CH_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CH_NUM-1:0]             ch_en,
  input  logic [CH_NUM-1:0]             s_axis_tvalid,
  output logic [CH_NUM-1:0]             s_axis_tready,
  input  logic [CH_NUM*DWIDTH-1:0]      s_axis_tdata,
  input  logic [CH_NUM*KWIDTH-1:0]      s_axis_tkeep,
  input  logic [CH_NUM*UWIDTH-1:0]      s_axis_tuser,
  input  logic [CH_NUM-1:0]             s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DWIDTH-1:0]             m_axis_tdata,
  output logic [KWIDTH-1:0]             m_axis_tkeep,
  output logic [UWIDTH-1:0]             m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic [CH_W-1:0]               m_axis_tid,
  output logic [CH_NUM*PKT_CNT_W-1:0]   pkt_cnt,
  output logic [CH_NUM-1:0]             err_ovlen,
  input  logic                          err_clr
);

  localparam int unsigned BC_W = $clog2(MAX_BEATS + 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CH_NUM-1:0] req;
  logic              load;
  logic [CH_W-1:0]   pick_idx;
  logic [CH_W-1:0]   grant_idx;
  logic [CH_NUM-1:0] grant_oh;
  logic              xfer;
  logic              beat_acc;
  logic              eop;
  logic              ovl_hit;

  logic [DWIDTH-1:0] ch_data [CH_NUM];
  logic [KWIDTH-1:0] ch_keep [CH_NUM];
  logic [UWIDTH-1:0] ch_user [CH_NUM];

  assign req  = s_axis_tvalid & ch_en;
  assign xfer = (state_q == ST_XFER);

  axis_rr_arb #(.N(CH_NUM)) u_rr_arb (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .load_i      (load),
    .pick_idx_o  (pick_idx),
    .grant_idx_o (grant_idx),
    .grant_oh_o  (grant_oh)
  );

  // Pass-through from the granted channel; valid is gated only by state, never by ready.
  assign m_axis_tvalid = xfer & s_axis_tvalid[grant_idx];
  assign m_axis_tdata  = ch_data[grant_idx];
  assign m_axis_tkeep  = ch_keep[grant_idx];
  assign m_axis_tuser  = ch_user[grant_idx];
  assign m_axis_tlast  = s_axis_tlast[grant_idx];
  assign m_axis_tid    = grant_idx;
  assign s_axis_tready = xfer ? (grant_oh & {CH_NUM{m_axis_tready}}) : '0;

  assign beat_acc = m_axis_tvalid & m_axis_tready;
  assign eop      = beat_acc & m_axis_tlast;
  assign ovl_hit  = beat_acc & ~m_axis_tlast & (beat_cnt_q == BC_W'(MAX_BEATS - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    load       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          load     = 1'b1;
          rr_ptr_d = pick_idx;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (eop) begin
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (beat_acc && (beat_cnt_q != BC_W'(MAX_BEATS))) begin
          // Saturates at MAX_BEATS so a runaway packet cannot wrap back onto the trigger value.
          beat_cnt_d = beat_cnt_q + BC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= CH_W'(CH_NUM - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 err_q, err_d;

    assign ch_data[i] = s_axis_tdata[i*DWIDTH +: DWIDTH];
    assign ch_keep[i] = s_axis_tkeep[i*KWIDTH +: KWIDTH];
    assign ch_user[i] = s_axis_tuser[i*UWIDTH +: UWIDTH];

    always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_d     = err_q;
      if (eop && grant_oh[i]) pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
      if (err_clr) err_d = 1'b0;
      if (ovl_hit && grant_oh[i]) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pkt_cnt_q <= '0;
        err_q     <= 1'b0;
      end else begin
        pkt_cnt_q <= pkt_cnt_d;
        err_q     <= err_d;
      end
    end

    assign pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] = pkt_cnt_q;
    assign err_ovlen[i]                      = err_q;
  end

endmodule

// File: doc/axis_chan_arb.md
Name: axis_chan_arb

Overview:
- N-channel AXI4-Stream packet arbiter that merges CH_NUM DMA stream channels into one master stream.
- Generalises the single DMA channel A command/data stream pair to a parametrised channel count.
- Provides round-robin packet-granular arbitration, per-channel enable, a channel-ID sideband on the merged stream, per-channel packet counters and an over-length packet checker.
- Sits between per-channel DMA stream sources and a single downstream stream consumer. Usable both in the shell datapath and behind the bench stream interfaces.

Parameters:
- CH_NUM, 4, number of slave channels (2..16).
- DWIDTH, 512, tdata width in bits.
- KWIDTH, 64, tkeep width; must equal DWIDTH/8.
- UWIDTH, 64, tuser width.
- MAX_BEATS, 256, maximum legal beats per packet, tlast beat included.
- CH_W, $clog2(CH_NUM), channel index width; derived, not to be overridden.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- ch_en  in  CH_NUM  per-channel arbitration enable.
- s_axis_tvalid  in  CH_NUM  slave valid, one bit per channel.
- s_axis_tready  out  CH_NUM  slave ready, one bit per channel.
- s_axis_tdata  in  CH_NUM*DWIDTH  slave data; channel i occupies slice [i*DWIDTH +: DWIDTH].
- s_axis_tkeep  in  CH_NUM*KWIDTH  slave byte keep, packed the same way as tdata.
- s_axis_tuser  in  CH_NUM*UWIDTH  slave user sideband, packed the same way as tdata.
- s_axis_tlast  in  CH_NUM  slave end of packet.
- m_axis_tvalid/tready/tdata/tkeep/tuser/tlast  out/in/out/out/out/out  1/1/DWIDTH/KWIDTH/UWIDTH/1  merged master stream.
- m_axis_tid  out  CH_W  index of the channel currently driving the master stream.
- pkt_cnt  out  CH_NUM*32  per-channel count of completed packets.
- err_ovlen  out  CH_NUM  sticky per-channel over-length flag.
- err_clr  in  1  synchronous clear of all err_ovlen bits.

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tid=0, pkt_cnt=0, err_ovlen=0, rr pointer=CH_NUM-1, beat counter=0, FSM=ST_IDLE.
- ST_IDLE:
  - req = s_axis_tvalid & ch_en.
  - If req is nonzero, pick the first set bit searching upward from rr_ptr+1, wrapping modulo CH_NUM.
  - Register the grant and set rr_ptr=grant; go to ST_XFER on the next cycle.
  - Arbitration latency is 1 cycle; all readies stay 0 in ST_IDLE.
- ST_XFER (combinational pass-through from the granted channel, zero added latency):
  - m_axis_tvalid = s_axis_tvalid[grant]; data, keep, user and last are muxed from channel grant.
  - s_axis_tready[grant] = m_axis_tready; all other readies are 0.
  - m_axis_tid = grant.
- Beat accepted when valid && ready on the master side; beat_cnt increments on each accepted beat.
- End of packet (accepted beat with tlast=1):
  - pkt_cnt[grant]++; wraps 0xFFFFFFFF->0 without a flag.
  - beat_cnt clears; FSM returns to ST_IDLE.
  - Back-to-back packets therefore have exactly one idle cycle between them.
- Over-length: if an accepted beat has tlast=0 and beat_cnt == MAX_BEATS-1, set err_ovlen[grant].
  - The transfer is not aborted; the packet continues until its real tlast.
  - The over-length packet is still counted in pkt_cnt.
- err_clr=1 clears all err_ovlen bits. If a set event and err_clr occur in the same cycle, the set wins.
- ch_en is sampled only in ST_IDLE. Deasserting it mid-packet does not interrupt the packet in progress.
- A granted channel may drop tvalid mid-packet; the grant is held and the arbiter waits indefinitely.
- With a single requester, that channel is re-granted every packet; the round-robin pointer has no effect.
- Reset asserted mid-packet: all state returns to reset values immediately (asynchronously). The partial packet is neither counted nor completed.
- Reset deassertion is synchronised externally; the block assumes clean release.
- Stream rules enforced on the master side:
  - m_axis_tvalid never depends on m_axis_tready.
  - Master data is stable while tvalid=1 and tready=0, provided the source obeys the same rule.

Decomposition:
- Package axis_chan_arb_pkg holds:
  - state enum {ST_IDLE, ST_XFER};
  - the counter width constant PKT_CNT_W=32;
  - the round-robin pick function rr_pick(req, ptr).
- One sub-module, axis_rr_arb: request vector plus pointer in, registered one-hot/index grant out, with a load strobe. It is reusable by future multi-port DDR/AXI4 arbiters.
- Per-channel slicing of packed vectors is done with generate blocks in the top module.

Test Plan:
- CH_NUM=4, all enabled, ch0..3 each send one 4-beat packet simultaneously, m_ready=1 -> grant order 0,1,2,3; m_axis_tid follows the same order; 4 beats per packet, 1 idle cycle between packets; pkt_cnt = {1,1,1,1}.
- ch2 only sends 3 consecutive 2-beat packets -> all granted to ch2; pkt_cnt[2]=3; other counters stay 0.
- ch_en=4'b1101 while ch1 is valid -> ch1 is never granted and s_axis_tready[1] stays 0; after ch_en[1]=1, ch1 is granted on the next arbitration.
- MAX_BEATS=8, ch0 sends a 10-beat packet -> err_ovlen[0] rises on the 8th beat (beat index 7); all 10 beats pass; pkt_cnt[0]=1; err_clr pulse -> err_ovlen=0.
- m_axis_tready toggles 1,0,0,1 during a ch3 packet -> no beat lost or duplicated; data/keep/user/tlast match the source order; s_axis_tready[3] mirrors m_axis_tready.
- Assert rst at beat 2 of a 5-beat ch1 packet -> next cycle all outputs are at reset values, pkt_cnt[1]=0; after release, a fresh ch1 packet is granted to channel 1.
